// File: rtl/la_pkg.sv
// la_pkg
// Shared types for the logic analyzer trace path. Both the trace encoder and
// the trace decoder import this package, so the word layout stays in one place.
//   LA_RC_W / LA_SIG_W : repeat-count and signal-snapshot widths
//   la_word_t          : one AXI-Stream trace word {rc, sig}, rc in the MSBs
//   la_entry_t         : one run held by the decoder while it is being expanded
//   la_buf_state_e     : occupancy of the decoder's two-entry run buffer
package la_pkg;

  localparam int LA_RC_W  = 8;
  localparam int LA_SIG_W = 24;

  typedef struct packed {
    logic [LA_RC_W-1:0]  rc;
    logic [LA_SIG_W-1:0] sig;
  } la_word_t;

  typedef struct packed {
    logic [LA_SIG_W-1:0] sig;
    logic [LA_RC_W-1:0]  remaining;
    logic                first;
    logic                last;
    logic                resync;
  } la_entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_RUN,
    BUF_FULL
  } la_buf_state_e;

endpackage

// File: rtl/la_trace_dec_buf.sv
// la_trace_dec_buf
// Two-entry run holder for the trace decoder. 'cur' is the run being expanded
// one beat at a time; 'nxt' parks one more run so the next run can start on the
// cycle right after 'cur' finishes, giving gap-free output.
//   clk, rst    : clock, asynchronous active-high reset
//   load_en     : a nonzero-count word is being accepted this cycle
//   load_entry  : the run built from that word
//   beat_ready  : downstream consumes the current beat when cur_valid is high
//   cur         : the run currently being expanded
//   cur_valid   : 'cur' holds a run (sample output is valid)
//   nxt_valid   : 'nxt' holds a run (no room for another word)
module la_trace_dec_buf
  import la_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_en,
  input  la_entry_t load_entry,
  input  logic      beat_ready,
  output la_entry_t cur,
  output logic      cur_valid,
  output logic      nxt_valid
);

  la_buf_state_e state_q, state_d;
  la_entry_t     cur_q, cur_d;
  la_entry_t     nxt_q, nxt_d;
  logic          beat;
  logic          cur_finish;

  assign cur_valid  = (state_q != BUF_EMPTY);
  assign nxt_valid  = (state_q == BUF_FULL);
  assign cur        = cur_q;
  assign beat       = cur_valid & beat_ready;
  assign cur_finish = beat & (cur_q.remaining == LA_RC_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      cur_q   <= '0;
      nxt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
    end
  end

  // A consumed beat always counts down and drops the first/resync tags; the
  // state case then overrides 'cur' when a finishing run is replaced.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    if (beat) begin
      cur_d.remaining = cur_q.remaining - LA_RC_W'(1);
      cur_d.first     = 1'b0;
      cur_d.resync    = 1'b0;
    end
    case (state_q)
      BUF_EMPTY: begin
        if (load_en) begin
          cur_d   = load_entry;
          state_d = BUF_RUN;
        end
      end
      BUF_RUN: begin
        if (cur_finish) begin
          if (load_en) cur_d = load_entry;
          else         state_d = BUF_EMPTY;
        end else if (load_en) begin
          nxt_d   = load_entry;
          state_d = BUF_FULL;
        end
      end
      BUF_FULL: begin
        // Upstream is stalled here, so only the hand-over can happen.
        if (cur_finish) begin
          cur_d   = nxt_q;
          state_d = BUF_RUN;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

endmodule

// File: rtl/la_trace_decoder.sv
// la_trace_decoder
// Re-expands run-length-encoded logic analyzer trace words into one sample per
// repeat. A word with repeat count 0 is an overflow marker: it is swallowed,
// flagged, and tags the first sample of the next run as a resync point.
// Optional stats counters are built when LA_TRACE_DEC_STATS_EN is defined.
//   axis_clk, axis_rst          : clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready : AXIS slave, {rc[31:24], sig[23:0]}
//   m_sample/m_valid/m_ready    : expanded sample stream
//   m_first, m_last, m_resync   : per-sample tags
//   ovf_pulse, ovf_sticky, ovf_clr : overflow indication and sticky clear
//   sample_cnt, ovf_cnt         : consumed beats / overflow words (stats build)
module la_trace_decoder
  import la_pkg::*;
#(
  parameter int RC_W  = LA_RC_W,
  parameter int SIG_W = LA_SIG_W
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst,
  input  logic [RC_W+SIG_W-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [SIG_W-1:0]      m_sample,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  m_resync,
  output logic                  ovf_pulse,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr,
  output logic [31:0]           sample_cnt,
  output logic [15:0]           ovf_cnt
);

  la_word_t  word;
  la_entry_t load_entry;
  la_entry_t cur;
  logic      cur_valid;
  logic      nxt_valid;
  logic      accept;
  logic      is_ovf;
  logic      load_en;
  logic      ovf_accept;
  logic      resync_pend;

  assign word       = s_tdata;
  // Ready comes straight from buffer state; reset masks it so nothing is
  // accepted while the buffer is being cleared.
  assign s_tready   = !nxt_valid && !axis_rst;
  assign accept     = s_tvalid & s_tready;
  assign is_ovf     = (word.rc == '0);
  assign load_en    = accept & !is_ovf;
  assign ovf_accept = accept & is_ovf;

  always_comb begin
    load_entry           = '0;
    load_entry.sig       = word.sig;
    load_entry.remaining = word.rc;
    load_entry.first     = 1'b1;
    load_entry.last      = s_tlast;
    load_entry.resync    = resync_pend;
  end

  la_trace_dec_buf u_buf (
    .clk        (axis_clk),
    .rst        (axis_rst),
    .load_en    (load_en),
    .load_entry (load_entry),
    .beat_ready (m_ready),
    .cur        (cur),
    .cur_valid  (cur_valid),
    .nxt_valid  (nxt_valid)
  );

  assign m_valid  = cur_valid;
  assign m_sample = cur_valid ? cur.sig : '0;
  assign m_first  = cur_valid & cur.first;
  assign m_last   = cur_valid & cur.last & (cur.remaining == LA_RC_W'(1));
  assign m_resync = cur_valid & cur.resync;

  // Overflow bookkeeping. Any run of overflow words leaves a single pending
  // resync that the next real word absorbs; a new overflow beats ovf_clr.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      resync_pend <= 1'b0;
      ovf_pulse   <= 1'b0;
      ovf_sticky  <= 1'b0;
    end else begin
      ovf_pulse <= ovf_accept;
      if (ovf_accept)   resync_pend <= 1'b1;
      else if (load_en) resync_pend <= 1'b0;
      if (ovf_accept)   ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  end

`ifdef LA_TRACE_DEC_STATS_EN
  // Sample count wraps; overflow count saturates so a flood stays visible.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      sample_cnt <= '0;
      ovf_cnt    <= '0;
    end else begin
      if (m_valid && m_ready) sample_cnt <= sample_cnt + 32'd1;
      if (ovf_accept && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`else
  assign sample_cnt = '0;
  assign ovf_cnt    = '0;
`endif

endmodule

// File: tb/tb_la_trace_decoder.sv
// tb_la_trace_decoder
// Directed bench for la_trace_decoder: per-cycle vector tables for the basic,
// stall and overflow sequences, plus hand-written back-to-back, long-run and
// reset-mid-run sequences. Inputs change 1ns after the rising edge; outputs
// are sampled on the falling edge.
module tb_la_trace_decoder;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic [31:0] s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast  = 1'b0;
  logic        s_tready;
  logic [23:0] m_sample;
  logic        m_valid;
  logic        m_ready  = 1'b0;
  logic        m_first;
  logic        m_last;
  logic        m_resync;
  logic        ovf_pulse;
  logic        ovf_sticky;
  logic        ovf_clr  = 1'b0;
  logic [31:0] sample_cnt;
  logic [15:0] ovf_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 axis_clk = ~axis_clk;

  la_trace_decoder dut (
    .axis_clk   (axis_clk),
    .axis_rst   (axis_rst),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_sample   (m_sample),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_first    (m_first),
    .m_last     (m_last),
    .m_resync   (m_resync),
    .ovf_pulse  (ovf_pulse),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
    .sample_cnt (sample_cnt),
    .ovf_cnt    (ovf_cnt)
  );

  // One cycle of stimulus and the outputs expected in that same cycle.
  typedef struct {
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        mready;
    logic        oclr;
    logic        e_tready;
    logic        e_valid;
    logic [23:0] e_sample;
    logic        e_first;
    logic        e_last;
    logic        e_resync;
    logic        e_pulse;
    logic        e_sticky;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [31:0] tdata, input logic tvalid, input logic tlast,
                        input logic mready, input logic oclr, input logic e_tready,
                        input logic e_valid, input logic [23:0] e_sample, input logic e_first,
                        input logic e_last, input logic e_resync, input logic e_pulse,
                        input logic e_sticky);
    vec_t v;
    v.tdata = tdata; v.tvalid = tvalid; v.tlast = tlast; v.mready = mready; v.oclr = oclr;
    v.e_tready = e_tready; v.e_valid = e_valid; v.e_sample = e_sample; v.e_first = e_first;
    v.e_last = e_last; v.e_resync = e_resync; v.e_pulse = e_pulse; v.e_sticky = e_sticky;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    s_tdata  = v.tdata;
    s_tvalid = v.tvalid;
    s_tlast  = v.tlast;
    m_ready  = v.mready;
    ovf_clr  = v.oclr;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkVal({tag, ".tready"}, 32'(s_tready),   32'(v.e_tready));
    checkVal({tag, ".valid"},  32'(m_valid),    32'(v.e_valid));
    checkVal({tag, ".sample"}, 32'(m_sample),   32'(v.e_sample));
    checkVal({tag, ".first"},  32'(m_first),    32'(v.e_first));
    checkVal({tag, ".last"},   32'(m_last),     32'(v.e_last));
    checkVal({tag, ".resync"}, 32'(m_resync),   32'(v.e_resync));
    checkVal({tag, ".pulse"},  32'(ovf_pulse),  32'(v.e_pulse));
    checkVal({tag, ".sticky"}, 32'(ovf_sticky), 32'(v.e_sticky));
  endtask

  task automatic runVectors(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge axis_clk);
      checkOutput(vecs[i], $sformatf("%s[%0d]", tag, i));
      tick();
    end
    vecs.delete();
  endtask

  task automatic idleInputs;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic applyReset;
    idleInputs();
    axis_rst = 1'b1;
    tick();
    tick();
    axis_rst = 1'b0;
  endtask

  function automatic logic [31:0] mkWord(input logic [7:0] rc, input logic [23:0] sig);
    return {rc, sig};
  endfunction

  initial begin
    int beats, last_cnt, last_beat, first_cnt, bad_sample, residual;

    // Outputs while reset is held.
    #1;
    checkVal("rst.tready", 32'(s_tready), 32'd0);
    checkVal("rst.valid",  32'(m_valid),  32'd0);
    checkVal("rst.sticky", 32'(ovf_sticky), 32'd0);
    checkVal("rst.pulse",  32'(ovf_pulse), 32'd0);
    checkVal("rst.scnt",   sample_cnt, 32'd0);
    tick();
    tick();
    axis_rst = 1'b0;
    @(negedge axis_clk);
    checkVal("rel.tready", 32'(s_tready), 32'd1);
    checkVal("rel.valid",  32'(m_valid),  32'd0);
    tick();

    // {2,5a} then {1,55} with tlast: 5a,5a,55 back to back.
    addVec(mkWord(8'd2, 24'h00005a), 1, 0, 1, 0,  1, 0, 24'h0,  0, 0, 0, 0, 0);
    addVec(mkWord(8'd1, 24'h000055), 1, 1, 1, 0,  1, 1, 24'h5a, 1, 0, 0, 0, 0);
    addVec(32'h0,                    0, 0, 1, 0,  0, 1, 24'h5a, 0, 0, 0, 0, 0);
    addVec(32'h0,                    0, 0, 1, 0,  1, 1, 24'h55, 1, 1, 0, 0, 0);
    addVec(32'h0,                    0, 0, 1, 0,  1, 0, 24'h0,  0, 0, 0, 0, 0);
    runVectors("basic");

    // {3,aa},{2,bb} with m_ready low for 5 cycles, then drained gap-free.
    addVec(mkWord(8'd3, 24'h0000aa), 1, 0, 0, 0,  1, 0, 24'h0,  0, 0, 0, 0, 0);
    addVec(mkWord(8'd2, 24'h0000bb), 1, 0, 0, 0,  1, 1, 24'haa, 1, 0, 0, 0, 0);
    addVec(32'h0,                    0, 0, 0, 0,  0, 1, 24'haa, 1, 0, 0, 0, 0);
    addVec(32'h0,                    0, 0, 0, 0,  0, 1, 24'haa, 1, 0, 0, 0, 0);
    addVec(32'h0,                    0, 0, 0, 0,  0, 1, 24'haa, 1, 0, 0, 0, 0);
    addVec(32'h0,                    0, 0, 1, 0,  0, 1, 24'haa, 1, 0, 0, 0, 0);
    addVec(32'h0,                    0, 0, 1, 0,  0, 1, 24'haa, 0, 0, 0, 0, 0);
    addVec(32'h0,                    0, 0, 1, 0,  0, 1, 24'haa, 0, 0, 0, 0, 0);
    addVec(32'h0,                    0, 0, 1, 0,  1, 1, 24'hbb, 1, 0, 0, 0, 0);
    addVec(32'h0,                    0, 0, 1, 0,  1, 1, 24'hbb, 0, 0, 0, 0, 0);
    addVec(32'h0,                    0, 0, 1, 0,  1, 0, 24'h0,  0, 0, 0, 0, 0);
    runVectors("stall");

    // Overflow marker then {4,c8}; clear; clr+set together; two markers then {1,11}.
    addVec(mkWord(8'd0, 24'hdead01), 1, 0, 1, 0,  1, 0, 24'h0,  0, 0, 0, 0, 0);
    addVec(mkWord(8'd4, 24'h0000c8), 1, 0, 1, 0,  1, 0, 24'h0,  0, 0, 0, 1, 1);
    addVec(32'h0,                    0, 0, 1, 0,  1, 1, 24'hc8, 1, 0, 1, 0, 1);
    addVec(32'h0,                    0, 0, 1, 0,  1, 1, 24'hc8, 0, 0, 0, 0, 1);
    addVec(32'h0,                    0, 0, 1, 0,  1, 1, 24'hc8, 0, 0, 0, 0, 1);
    addVec(32'h0,                    0, 0, 1, 0,  1, 1, 24'hc8, 0, 0, 0, 0, 1);
    addVec(32'h0,                    0, 0, 1, 1,  1, 0, 24'h0,  0, 0, 0, 0, 1);
    addVec(mkWord(8'd0, 24'h000001), 1, 0, 1, 1,  1, 0, 24'h0,  0, 0, 0, 0, 0);
    addVec(mkWord(8'd0, 24'h000002), 1, 0, 1, 0,  1, 0, 24'h0,  0, 0, 0, 1, 1);
    addVec(mkWord(8'd1, 24'h000011), 1, 0, 1, 0,  1, 0, 24'h0,  0, 0, 0, 1, 1);
    addVec(32'h0,                    0, 0, 1, 0,  1, 1, 24'h11, 1, 0, 1, 0, 1);
    addVec(32'h0,                    0, 0, 1, 0,  1, 0, 24'h0,  0, 0, 0, 0, 1);
    runVectors("ovf");

    // 200 back-to-back rc=1 words: one sample per cycle, ready never drops.
    m_ready = 1'b1;
    for (int k = 0; k <= 200; k++) begin
      s_tvalid = (k < 200);
      s_tdata  = (k < 200) ? mkWord(8'd1, 24'(k)) : 32'h0;
      @(negedge axis_clk);
      if (k < 200) checkVal($sformatf("b2b[%0d].tready", k), 32'(s_tready), 32'd1);
      if (k >= 1) begin
        checkVal($sformatf("b2b[%0d].valid", k), 32'(m_valid), 32'd1);
        checkVal($sformatf("b2b[%0d].sample", k), 32'(m_sample), 32'(k - 1));
        checkVal($sformatf("b2b[%0d].first", k), 32'(m_first), 32'd1);
      end
      tick();
    end
    @(negedge axis_clk);
    checkVal("b2b.end_valid", 32'(m_valid), 32'd0);
    tick();

    // {255,123456} with tlast: exactly 255 beats, m_last on the final one.
    applyReset();
    m_ready  = 1'b1;
    s_tvalid = 1'b1;
    s_tlast  = 1'b1;
    s_tdata  = mkWord(8'd255, 24'h123456);
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    beats = 0; last_cnt = 0; last_beat = 0; first_cnt = 0; bad_sample = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge axis_clk);
      if (m_valid) begin
        beats++;
        if (m_sample !== 24'h123456) bad_sample++;
        if (m_first) first_cnt++;
        if (m_last) begin
          last_cnt++;
          last_beat = beats;
        end
      end
      tick();
    end
    checkVal("long.beats",     32'(beats),      32'd255);
    checkVal("long.last_cnt",  32'(last_cnt),   32'd1);
    checkVal("long.last_beat", 32'(last_beat),  32'd255);
    checkVal("long.first_cnt", 32'(first_cnt),  32'd1);
    checkVal("long.bad_sample", 32'(bad_sample), 32'd0);
`ifdef LA_TRACE_DEC_STATS_EN
    checkVal("long.sample_cnt", sample_cnt, 32'd255);
`else
    checkVal("long.sample_cnt", sample_cnt, 32'd0);
`endif

    // Overflow, then {10,77}; reset lands during the 3rd beat.
    s_tvalid = 1'b1;
    s_tdata  = mkWord(8'd0, 24'h0);
    tick();
    s_tdata  = mkWord(8'd10, 24'h000077);
    tick();
    s_tvalid = 1'b0;
    s_tdata  = '0;
    tick();
    tick();
    checkVal("rmid.valid_before", 32'(m_valid), 32'd1);
    checkVal("rmid.sticky_before", 32'(ovf_sticky), 32'd1);
    axis_rst = 1'b1;
    #1;
    checkVal("rmid.valid_now",  32'(m_valid),    32'd0);
    checkVal("rmid.tready_now", 32'(s_tready),   32'd0);
    checkVal("rmid.sticky_now", 32'(ovf_sticky), 32'd0);
    tick();
    tick();
    axis_rst = 1'b0;
    residual = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge axis_clk);
      if (m_valid) residual++;
      tick();
    end
    checkVal("rmid.residual", 32'(residual), 32'd0);
    @(negedge axis_clk);
    checkVal("rmid.tready_after", 32'(s_tready), 32'd1);
    tick();
    s_tvalid = 1'b1;
    s_tdata  = mkWord(8'd1, 24'h000022);
    tick();
    s_tvalid = 1'b0;
    s_tdata  = '0;
    @(negedge axis_clk);
    checkVal("rmid.new_valid",  32'(m_valid),  32'd1);
    checkVal("rmid.new_sample", 32'(m_sample), 32'h22);
    checkVal("rmid.new_resync", 32'(m_resync), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
